// File: rtl/mips_pkg.sv
// Shared MIPS-style definitions used by the encoder and the decode stage.
package mips_pkg;

  localparam int REGISTERWIDTH = 5;

  typedef enum logic [5:0] {
    OP_ADD  = 6'h00, OP_ADDI = 6'h01, OP_SUB  = 6'h02, OP_SUBI = 6'h03,
    OP_MUL  = 6'h04, OP_MULI = 6'h05, OP_AND  = 6'h06, OP_ANDI = 6'h07,
    OP_OR   = 6'h08, OP_ORI  = 6'h09, OP_XOR  = 6'h0A, OP_XORI = 6'h0B,
    OP_LDW  = 6'h0C, OP_STW  = 6'h0D, OP_BZ   = 6'h0E, OP_BEQ  = 6'h0F,
    OP_JR   = 6'h10, OP_HALT = 6'h11
  } opcode_e;

  // Opcode class ranges (inclusive upper bounds; each class starts after the previous one).
  localparam logic [5:0] ARITH_HI  = 6'h05;
  localparam logic [5:0] LOGIC_LO  = 6'h06;
  localparam logic [5:0] LOGIC_HI  = 6'h0B;
  localparam logic [5:0] MEM_LO    = 6'h0C;
  localparam logic [5:0] MEM_HI    = 6'h0D;
  localparam logic [5:0] BRANCH_LO = 6'h0E;
  localparam logic [5:0] OP_MAX    = 6'h11;

  typedef enum logic {ST_RUN, ST_HALTED} enc_state_e;

  typedef struct packed {
    logic [5:0]               op;
    logic [REGISTERWIDTH-1:0] rs;
    logic [REGISTERWIDTH-1:0] rt;
    logic [REGISTERWIDTH-1:0] rd;
    logic [10:0]              pad;
  } r_instr_t;

  typedef struct packed {
    logic [5:0]               op;
    logic [REGISTERWIDTH-1:0] rs;
    logic [REGISTERWIDTH-1:0] rt;
    logic [15:0]              imm;
  } i_instr_t;

  typedef union packed {
    r_instr_t r;
    i_instr_t i;
  } instruct_u;

  // Build the 32-bit word for a legal opcode; the caller screens illegal ones.
  function automatic instruct_u encode(input logic [5:0] op,
                                       input logic [REGISTERWIDTH-1:0] rs,
                                       input logic [REGISTERWIDTH-1:0] rt,
                                       input logic [REGISTERWIDTH-1:0] rd,
                                       input logic [15:0] imm);
    instruct_u w;
    w = '0;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR: begin
        w.r.op = op; w.r.rs = rs; w.r.rt = rt; w.r.rd = rd; w.r.pad = '0;
      end
      OP_BZ, OP_JR: begin
        w.i.op = op; w.i.rs = rs; w.i.rt = '0; w.i.imm = imm;
      end
      OP_HALT: begin
        w.i.op = op;
      end
      default: begin
        w.i.op = op; w.i.rs = rs; w.i.rt = rt; w.i.imm = imm;
      end
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mips_instr_encoder_if.sv
// Field-bundle input, encoded-word output and status/counter bus of the encoder.
interface mips_instr_encoder_if;
  import mips_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic [5:0]               in_opcode;
  logic [REGISTERWIDTH-1:0] in_rs;
  logic [REGISTERWIDTH-1:0] in_rt;
  logic [REGISTERWIDTH-1:0] in_rd;
  logic [15:0]              in_imm;
  logic                     clear;
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_instr;
  logic [31:0]              out_addr;
  logic                     illegal;
  logic                     halted;
  logic [31:0]              cnt_total;
  logic [31:0]              cnt_arith;
  logic [31:0]              cnt_logic;
  logic [31:0]              cnt_mem;
  logic [31:0]              cnt_branch;

  modport master (
    output in_valid, in_opcode, in_rs, in_rt, in_rd, in_imm, clear, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, illegal, halted,
           cnt_total, cnt_arith, cnt_logic, cnt_mem, cnt_branch
  );

  modport slave (
    input  in_valid, in_opcode, in_rs, in_rt, in_rd, in_imm, clear, out_ready,
    output in_ready, out_valid, out_instr, out_addr, illegal, halted,
           cnt_total, cnt_arith, cnt_logic, cnt_mem, cnt_branch
  );
endinterface

// File: rtl/mips_instr_encoder_enc_fifo.sv
// Output queue holding {instruction, address} pairs; first-word-fall-through read.
module enc_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pointer and occupancy tracking; simultaneous push/pop leaves occupancy unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; contents are meaningless while empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/mips_instr_encoder.sv
// Encodes MIPS-style field bundles into 32-bit words, tags each with a byte
// address and queues them; HALT stops intake until a clear restarts it.
module mips_instr_encoder
  import mips_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic               clock,
  input  logic               reset,
  mips_instr_encoder_if.slave bus
);
  enc_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] cnt_total_q, cnt_total_d;
  logic [31:0] cnt_arith_q, cnt_arith_d;
  logic [31:0] cnt_logic_q, cnt_logic_d;
  logic [31:0] cnt_mem_q, cnt_mem_d;
  logic [31:0] cnt_branch_q, cnt_branch_d;
  logic        illegal_q;

  logic        in_ready_w;
  logic        halted_w;
  logic        fifo_full;
  logic        fifo_empty;
  logic [63:0] fifo_rdata;
  logic        accept;
  logic        legal;
  logic        push;
  logic        pop;
  logic        clear_en;
  instruct_u   enc_word;

  assign legal    = (bus.in_opcode <= OP_MAX);
  assign accept   = bus.in_valid && in_ready_w;
  assign push     = accept && legal;
  assign pop      = bus.out_valid && bus.out_ready;
  assign clear_en = (state_q == ST_HALTED) && bus.clear;
  assign enc_word = encode(bus.in_opcode, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_imm);

  enc_fifo #(.DEPTH(DEPTH), .W(64)) u_fifo (
    .clk     (clock),
    .rst     (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({enc_word, addr_q}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Next state: HALT acceptance stops intake, clear in HALTED restarts it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (push && (bus.in_opcode == OP_HALT)) state_d = ST_HALTED;
      ST_HALTED: if (bus.clear) state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  // State-derived outputs; in_ready never looks at out_ready.
  always_comb begin
    in_ready_w = (state_q == ST_RUN) && !fifo_full;
    halted_w   = (state_q == ST_HALTED) && fifo_empty;
  end

  // Address and class counters: cleared on restart, advanced on each legal push.
  always_comb begin
    addr_d       = addr_q;
    cnt_total_d  = cnt_total_q;
    cnt_arith_d  = cnt_arith_q;
    cnt_logic_d  = cnt_logic_q;
    cnt_mem_d    = cnt_mem_q;
    cnt_branch_d = cnt_branch_q;
    if (clear_en) begin
      addr_d       = BASE_ADDR;
      cnt_total_d  = '0;
      cnt_arith_d  = '0;
      cnt_logic_d  = '0;
      cnt_mem_d    = '0;
      cnt_branch_d = '0;
    end else if (push) begin
      addr_d      = addr_q + 32'd4;
      cnt_total_d = cnt_total_q + 32'd1;
      if (bus.in_opcode <= ARITH_HI)
        cnt_arith_d = cnt_arith_q + 32'd1;
      else if ((bus.in_opcode >= LOGIC_LO) && (bus.in_opcode <= LOGIC_HI))
        cnt_logic_d = cnt_logic_q + 32'd1;
      else if ((bus.in_opcode >= MEM_LO) && (bus.in_opcode <= MEM_HI))
        cnt_mem_d = cnt_mem_q + 32'd1;
      else if (bus.in_opcode >= BRANCH_LO)
        cnt_branch_d = cnt_branch_q + 32'd1;
    end
  end

  // Datapath registers plus the one-cycle illegal-opcode pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q       <= BASE_ADDR;
      cnt_total_q  <= '0;
      cnt_arith_q  <= '0;
      cnt_logic_q  <= '0;
      cnt_mem_q    <= '0;
      cnt_branch_q <= '0;
      illegal_q    <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      cnt_total_q  <= cnt_total_d;
      cnt_arith_q  <= cnt_arith_d;
      cnt_logic_q  <= cnt_logic_d;
      cnt_mem_q    <= cnt_mem_d;
      cnt_branch_q <= cnt_branch_d;
      illegal_q    <= accept && !legal;
    end
  end

  assign bus.in_ready   = in_ready_w;
  assign bus.halted     = halted_w;
  assign bus.out_valid  = !fifo_empty;
  assign bus.out_instr  = fifo_rdata[63:32];
  assign bus.out_addr   = fifo_rdata[31:0];
  assign bus.illegal    = illegal_q;
  assign bus.cnt_total  = cnt_total_q;
  assign bus.cnt_arith  = cnt_arith_q;
  assign bus.cnt_logic  = cnt_logic_q;
  assign bus.cnt_mem    = cnt_mem_q;
  assign bus.cnt_branch = cnt_branch_q;
endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed bench for mips_instr_encoder: inputs change on the falling edge,
// outputs are sampled on the falling edge after each rising edge.
module tb_mips_instr_encoder;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  mips_instr_encoder_if bus();

  mips_instr_encoder #(.DEPTH(4), .BASE_ADDR(32'h0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic send(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm);
    bus.in_valid = 1'b1; bus.in_opcode = op; bus.in_rs = rs; bus.in_rt = rt;
    bus.in_rd = rd; bus.in_imm = imm;
    @(negedge clock);
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_rs = '0; bus.in_rt = '0;
    bus.in_rd = '0; bus.in_imm = '0; bus.clear = 1'b0; bus.out_ready = 1'b0;
    reset = 1'b1;
    @(negedge clock); @(negedge clock);
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.halted !== 1'b0) $display("FAIL reset_halted got %b exp 0", bus.halted); else pass_cnt++;
    total_cnt++; if (bus.illegal !== 1'b0) $display("FAIL reset_illegal got %b exp 0", bus.illegal); else pass_cnt++;
    reset = 1'b0;
    @(negedge clock);
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); else pass_cnt++;
    total_cnt++; if (bus.cnt_total !== 32'd0) $display("FAIL reset_cnt_total got %0d exp 0", bus.cnt_total); else pass_cnt++;
  endtask

  task automatic test_rtype();
    bus.out_ready = 1'b1;
    send(6'h00, 5'd1, 5'd2, 5'd3, 16'h0);
    total_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL add_out_valid got %b exp 1", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.out_instr !== 32'h00221800) $display("FAIL add_instr got %h exp 00221800", bus.out_instr); else pass_cnt++;
    total_cnt++; if (bus.out_addr !== 32'h0) $display("FAIL add_addr got %h exp 00000000", bus.out_addr); else pass_cnt++;
    total_cnt++; if (bus.cnt_arith !== 32'd1) $display("FAIL add_cnt_arith got %0d exp 1", bus.cnt_arith); else pass_cnt++;
  endtask

  task automatic test_itype();
    send(6'h01, 5'd4, 5'd5, 5'd0, 16'hFFFF);
    total_cnt++; if (bus.out_instr !== 32'h0485FFFF) $display("FAIL addi_instr got %h exp 0485ffff", bus.out_instr); else pass_cnt++;
    total_cnt++; if (bus.out_addr !== 32'h4) $display("FAIL addi_addr got %h exp 00000004", bus.out_addr); else pass_cnt++;
    send(6'h0D, 5'd1, 5'd2, 5'd0, 16'h0008);
    total_cnt++; if (bus.out_instr !== 32'h34220008) $display("FAIL stw_instr got %h exp 34220008", bus.out_instr); else pass_cnt++;
    total_cnt++; if (bus.out_addr !== 32'h8) $display("FAIL stw_addr got %h exp 00000008", bus.out_addr); else pass_cnt++;
    total_cnt++; if (bus.cnt_mem !== 32'd1) $display("FAIL stw_cnt_mem got %0d exp 1", bus.cnt_mem); else pass_cnt++;
    total_cnt++; if (bus.cnt_total !== 32'd3) $display("FAIL itype_cnt_total got %0d exp 3", bus.cnt_total); else pass_cnt++;
    // A clear while running must be ignored.
    bus.clear = 1'b1;
    @(negedge clock);
    bus.clear = 1'b0;
    total_cnt++; if (bus.cnt_total !== 32'd3) $display("FAIL clear_in_run_cnt got %0d exp 3", bus.cnt_total); else pass_cnt++;
  endtask

  task automatic test_illegal();
    bus.out_ready = 1'b1;
    send(6'h3F, 5'd1, 5'd2, 5'd3, 16'h1234);
    total_cnt++; if (bus.illegal !== 1'b1) $display("FAIL illegal_pulse got %b exp 1", bus.illegal); else pass_cnt++;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL illegal_out_valid got %b exp 0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.cnt_total !== 32'd3) $display("FAIL illegal_cnt_total got %0d exp 3", bus.cnt_total); else pass_cnt++;
    @(negedge clock);
    total_cnt++; if (bus.illegal !== 1'b0) $display("FAIL illegal_width got %b exp 0", bus.illegal); else pass_cnt++;
    send(6'h00, 5'd1, 5'd2, 5'd3, 16'h0);
    total_cnt++; if (bus.out_addr !== 32'hC) $display("FAIL illegal_addr_kept got %h exp 0000000c", bus.out_addr); else pass_cnt++;
    total_cnt++; if (bus.cnt_total !== 32'd4) $display("FAIL illegal_next_cnt got %0d exp 4", bus.cnt_total); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int  k;
    bit  acc;
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(6'h00, 5'd1, 5'd2, 5'(i), 16'h0);
    total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL full_in_ready got %b exp 0", bus.in_ready); else pass_cnt++;
    @(negedge clock);
    total_cnt++; if (bus.out_addr !== 32'h0) $display("FAIL hold_addr got %h exp 00000000", bus.out_addr); else pass_cnt++;
    total_cnt++; if (bus.out_instr !== 32'h00220000) $display("FAIL hold_instr got %h exp 00220000", bus.out_instr); else pass_cnt++;
    bus.in_valid = 1'b1; bus.in_opcode = 6'h00; bus.in_rs = 5'd1; bus.in_rt = 5'd2;
    bus.in_rd = 5'd4; bus.in_imm = 16'h0;
    bus.out_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 12 && k < 5; c++) begin
      if (bus.out_valid === 1'b1) begin
        total_cnt++; if (bus.out_addr !== 32'(k * 4)) $display("FAIL drain_addr%0d got %h exp %h", k, bus.out_addr, 32'(k * 4)); else pass_cnt++;
        total_cnt++; if (bus.out_instr !== (32'h00220000 | 32'(k << 11))) $display("FAIL drain_instr%0d got %h exp %h", k, bus.out_instr, 32'h00220000 | 32'(k << 11)); else pass_cnt++;
        k++;
      end
      acc = bus.in_valid && bus.in_ready;
      @(negedge clock);
      if (acc) bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0;
    total_cnt++; if (k != 5) $display("FAIL drain_count got %0d exp 5", k); else pass_cnt++;
  endtask

  task automatic test_halt();
    do_reset();
    bus.out_ready = 1'b0;
    send(6'h0A, 5'd1, 5'd2, 5'd3, 16'h0);
    send(6'h11, 5'd0, 5'd0, 5'd0, 16'h0);
    total_cnt++; if (bus.halted !== 1'b0) $display("FAIL halt_not_drained got %b exp 0", bus.halted); else pass_cnt++;
    total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL halt_in_ready got %b exp 0", bus.in_ready); else pass_cnt++;
    send(6'h00, 5'd1, 5'd2, 5'd3, 16'h0);
    total_cnt++; if (bus.cnt_total !== 32'd2) $display("FAIL halt_add_rejected got %0d exp 2", bus.cnt_total); else pass_cnt++;
    total_cnt++; if (bus.cnt_logic !== 32'd1) $display("FAIL halt_cnt_logic got %0d exp 1", bus.cnt_logic); else pass_cnt++;
    total_cnt++; if (bus.cnt_branch !== 32'd1) $display("FAIL halt_cnt_branch got %0d exp 1", bus.cnt_branch); else pass_cnt++;
    total_cnt++; if (bus.out_instr !== 32'h28221800) $display("FAIL xor_instr got %h exp 28221800", bus.out_instr); else pass_cnt++;
    bus.out_ready = 1'b1;
    @(negedge clock);
    total_cnt++; if (bus.out_instr !== 32'h44000000) $display("FAIL halt_instr got %h exp 44000000", bus.out_instr); else pass_cnt++;
    total_cnt++; if (bus.out_addr !== 32'h4) $display("FAIL halt_addr got %h exp 00000004", bus.out_addr); else pass_cnt++;
    @(negedge clock);
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL halt_drained_valid got %b exp 0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.halted !== 1'b1) $display("FAIL halted_flag got %b exp 1", bus.halted); else pass_cnt++;
    bus.clear = 1'b1;
    @(negedge clock);
    bus.clear = 1'b0;
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL clear_in_ready got %b exp 1", bus.in_ready); else pass_cnt++;
    total_cnt++; if (bus.halted !== 1'b0) $display("FAIL clear_halted got %b exp 0", bus.halted); else pass_cnt++;
    total_cnt++; if (bus.cnt_total !== 32'd0) $display("FAIL clear_cnt_total got %0d exp 0", bus.cnt_total); else pass_cnt++;
    send(6'h00, 5'd1, 5'd2, 5'd3, 16'h0);
    total_cnt++; if (bus.out_addr !== 32'h0) $display("FAIL clear_addr got %h exp 00000000", bus.out_addr); else pass_cnt++;
  endtask

  task automatic test_reset_midflight();
    @(negedge clock);
    bus.out_ready = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 3; i++) send(6'h02, 5'd1, 5'd2, 5'd3, 16'h0);
    total_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL mid_queued_valid got %b exp 1", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.cnt_arith !== 32'd4) $display("FAIL mid_cnt_arith got %0d exp 4", bus.cnt_arith); else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL mid_reset_valid got %b exp 0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.cnt_total !== 32'd0) $display("FAIL mid_reset_cnt_total got %0d exp 0", bus.cnt_total); else pass_cnt++;
    total_cnt++; if (bus.cnt_arith !== 32'd0) $display("FAIL mid_reset_cnt_arith got %0d exp 0", bus.cnt_arith); else pass_cnt++;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL mid_reset_in_ready got %b exp 1", bus.in_ready); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_illegal();
    test_back_to_back();
    test_halt();
    test_reset_midflight();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
